// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: write/read sequencer for a DIM x DIM ping-pong pixel buffer.
// Optional frame/stall status counters are built when PPB_STATUS_EN is defined.
module pingpong_ctrl #(
    parameter int DIM   = 34,
    parameter int AW    = $clog2(DIM),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [AW-1:0]    wr_row,
    output logic [AW-1:0]    wr_col,
    output logic             frame_done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_bank,
    output logic [DIM-1:0]   rd_row_sel,
    output logic             rd_done,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [AW-1:0]  LAST = AW'(DIM - 1);
    localparam logic [AW-1:0]  IDX1 = AW'(1);
    localparam logic [DIM-1:0] SEL0 = DIM'(1);

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_row;
    logic [AW-1:0] r_wr_col;
    logic          r_rd_bank;
    logic [AW-1:0] r_rd_row;
    logic          r_frame_done;
    logic          r_rd_done;

    logic          w_in_ready;
    logic          w_wr_en;
    logic          w_rd_valid;
    logic          w_rd_take;
    logic          w_wr_last;
    logic          w_rd_last;
    logic [1:0]    w_full_set;
    logic [1:0]    w_full_clr;

    // rst_n gates in_ready so nothing is accepted while reset is held
    assign w_in_ready = rst_n & en & ~r_full[r_wr_bank] & ~clr;
    assign w_wr_en    = in_valid & w_in_ready;
    assign w_rd_valid = en & r_full[r_rd_bank] & ~clr;
    assign w_rd_take  = w_rd_valid & rd_ready;
    assign w_wr_last  = w_wr_en & (r_wr_row == LAST) & (r_wr_col == LAST);
    assign w_rd_last  = w_rd_take & (r_rd_row == LAST);

    assign w_full_set = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else if (clr) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
        end else if (clr) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
        end else if (w_wr_en) begin
            if (r_wr_col == LAST) begin
                r_wr_col <= '0;
                if (r_wr_row == LAST) begin
                    r_wr_row  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_row <= r_wr_row + IDX1;
                end
            end else begin
                r_wr_col <= r_wr_col + IDX1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
        end else if (clr) begin
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
        end else if (w_rd_take) begin
            if (r_rd_row == LAST) begin
                r_rd_row  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else begin
                r_rd_row <= r_rd_row + IDX1;
            end
        end
    end

    // pulses run regardless of en so a registered pulse always lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_rd_done    <= 1'b0;
        end else if (clr) begin
            r_frame_done <= 1'b0;
            r_rd_done    <= 1'b0;
        end else begin
            r_frame_done <= w_wr_last;
            r_rd_done    <= w_rd_last;
        end
    end

`ifdef PPB_STATUS_EN
    localparam logic [CNT_W-1:0] CNT1 = CNT_W'(1);

    logic [CNT_W-1:0] r_frm_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (clr) begin
            r_frm_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_frame_done && (r_frm_cnt != '1)) begin
                r_frm_cnt <= r_frm_cnt + CNT1;
            end
            if (in_valid && !w_in_ready && en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT1;
            end
        end
    end

    assign frm_cnt   = r_frm_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign frm_cnt   = '0;
    assign stall_cnt = '0;
`endif

    assign in_ready   = w_in_ready;
    assign wr_en      = w_wr_en;
    assign wr_bank    = r_wr_bank;
    assign wr_row     = r_wr_row;
    assign wr_col     = r_wr_col;
    assign frame_done = r_frame_done;
    assign rd_valid   = w_rd_valid;
    assign rd_bank    = r_rd_bank;
    assign rd_row_sel = SEL0 << r_rd_row;
    assign rd_done    = r_rd_done;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl: directed vector table plus hand-written sequences
// for streaming, back-pressure, overlap, flush/reset and enable gating.
module tb_pingpong_ctrl;
    localparam int DIM   = 34;
    localparam int AW    = 6;
    localparam int CNT_W = 16;
    localparam int NPIX  = DIM * DIM;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic             in_ready;
    logic             wr_en;
    logic             wr_bank;
    logic [AW-1:0]    wr_row;
    logic [AW-1:0]    wr_col;
    logic             frame_done;
    logic             rd_valid;
    logic             rd_bank;
    logic [DIM-1:0]   rd_row_sel;
    logic             rd_done;
    logic [CNT_W-1:0] frm_cnt;
    logic [CNT_W-1:0] stall_cnt;

    pingpong_ctrl #(.DIM(DIM), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
        .frame_done(frame_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_bank(rd_bank), .rd_row_sel(rd_row_sel), .rd_done(rd_done),
        .frm_cnt(frm_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    ctl;
        logic [AW-1:0] col;
    } vec_t;

    vec_t           tbl [11];
    int             checks = 0;
    int             failures = 0;
    int             bad;
    int             fdc;
    int             rdc;
    int             p;
    int             s;
    logic           e_rv;
    logic           e_rb;
    logic           e_fd;
    logic           e_rd;
    int             e_row;
    logic [DIM-1:0] one_sel = 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic c,
                         input logic v, input logic r);
        en = e;
        clr = c;
        in_valid = v;
        rd_ready = r;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        rd_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] ctl, input logic [AW-1:0] col);
        vec_t v;
        v.ctl = ctl;
        v.col = col;
        return v;
    endfunction

    initial begin
        // ctl = {en, clr, in_valid, rd_ready, in_ready, wr_en, frame_done, rd_valid}
        tbl[0]  = mk(8'b1000_1000, 6'd0);
        tbl[1]  = mk(8'b1010_1100, 6'd0);
        tbl[2]  = mk(8'b1010_1100, 6'd1);
        tbl[3]  = mk(8'b1000_1000, 6'd2);
        tbl[4]  = mk(8'b0010_0000, 6'd2);
        tbl[5]  = mk(8'b0011_0000, 6'd2);
        tbl[6]  = mk(8'b1010_1100, 6'd2);
        tbl[7]  = mk(8'b1010_1100, 6'd3);
        tbl[8]  = mk(8'b1110_0000, 6'd4);
        tbl[9]  = mk(8'b1010_1100, 6'd0);
        tbl[10] = mk(8'b1000_1000, 6'd1);

        // reset state with all inputs active
        rst_n = 1'b0;
        en = 1'b1;
        in_valid = 1'b1;
        rd_ready = 1'b1;
        step();
        #2;
        chk("rst_handshake", {in_ready, wr_en, rd_valid}, 3'b000);
        chk("rst_pulses", {frame_done, rd_done}, 2'b00);
        chk("rst_idx", {wr_bank, wr_row, wr_col, rd_bank}, 0);
        chk("rst_sel", rd_row_sel, one_sel);
        chk("rst_cnt", {frm_cnt, stall_cnt}, 0);

        // vector table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ctl[7], tbl[i].ctl[6], tbl[i].ctl[5], tbl[i].ctl[4]);
            chk($sformatf("vec%0d", i),
                {in_ready, wr_en, frame_done, rd_valid, wr_bank, wr_row, wr_col},
                {tbl[i].ctl[3:0], 1'b0, 6'd0, tbl[i].col});
            step();
        end

        // single frame, no reads
        do_reset();
        bad = 0;
        fdc = 0;
        for (int t = 0; t < NPIX; t++) begin
            drive(1, 0, 1, 0);
            if (!(wr_en && !wr_bank && wr_row == AW'(t / DIM)
                  && wr_col == AW'(t % DIM) && !rd_valid)) bad++;
            if (frame_done) fdc++;
            step();
        end
        chk("frame_walk", bad, 0);
        chk("frame_no_early_done", fdc, 0);
        drive(1, 0, 0, 0);
        chk("frame_done_pulse", frame_done, 1);
        chk("frame_rd_valid", {rd_valid, rd_bank}, 2'b10);
        chk("frame_wr_after", {wr_bank, wr_row, wr_col, in_ready}, {1'b1, 12'd0, 1'b1});
        step();
        drive(1, 0, 0, 0);
        chk("frame_done_once", frame_done, 0);

        // three frames, reads held off
        do_reset();
        for (int t = 0; t < 2 * NPIX; t++) begin
            drive(1, 0, 1, 0);
            step();
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 0);
            if (in_ready || wr_en || !rd_valid) bad++;
            step();
        end
        chk("bp_stall", bad, 0);
        bad = 0;
        for (int k = 0; k < DIM; k++) begin
            drive(1, 0, 1, 1);
            if (in_ready || !rd_valid || rd_bank || rd_row_sel != (one_sel << k)) bad++;
            step();
        end
        chk("bp_drain", bad, 0);
        drive(1, 0, 1, 0);
        chk("bp_resume", {in_ready, wr_en, wr_bank, wr_row, wr_col}, {2'b11, 13'd0});
        chk("bp_rd_done", {rd_done, rd_bank, rd_valid}, 3'b111);
`ifdef PPB_STATUS_EN
        chk("bp_stall_cnt", stall_cnt, 39);
        chk("bp_frm_cnt", frm_cnt, 2);
`else
        chk("bp_cnt_tied", {frm_cnt, stall_cnt}, 0);
`endif
        step();

        // concurrent write and read
        do_reset();
        bad = 0;
        fdc = 0;
        rdc = 0;
        for (int t = 0; t <= 3 * NPIX + DIM; t++) begin
            drive(1, 0, 1, 1);
            p = t % NPIX;
            e_rv = 1'b0;
            e_rb = 1'b0;
            e_row = 0;
            e_rd = 1'b0;
            e_fd = (t > 0) && (p == 0);
            for (int k = 0; k < 3; k++) begin
                s = NPIX * (k + 1);
                if (t >= s && t < s + DIM) begin
                    e_rv = 1'b1;
                    e_rb = k[0];
                    e_row = t - s;
                end
                if (t == s + DIM) e_rd = 1'b1;
            end
            if (!(in_ready && wr_en && wr_bank == (((t / NPIX) % 2) == 1)
                  && wr_row == AW'(p / DIM) && wr_col == AW'(p % DIM))) bad++;
            if (rd_valid !== e_rv) bad++;
            if (e_rv && (rd_bank !== e_rb || rd_row_sel !== (one_sel << e_row))) bad++;
            if (frame_done !== e_fd || rd_done !== e_rd) bad++;
            if (frame_done) fdc++;
            if (rd_done) rdc++;
            step();
        end
        chk("conc_walk", bad, 0);
        chk("conc_pulses", {fdc[7:0], rdc[7:0]}, {8'd3, 8'd3});
`ifdef PPB_STATUS_EN
        chk("conc_cnt", {frm_cnt, stall_cnt}, {16'd3, 16'd0});
`endif

        // same-cycle completion of write to B and read of A
        do_reset();
        for (int t = 0; t < NPIX; t++) begin
            drive(1, 0, 1, 0);
            step();
        end
        for (int t = 0; t < NPIX; t++) begin
            drive(1, 0, 1, (t >= NPIX - DIM));
            if (t == NPIX - 1) begin
                chk("same_pre_full", dut.r_full, 2'b01);
                chk("same_pre_io", {wr_en, wr_bank, rd_valid, rd_bank, rd_row_sel[DIM-1]},
                    5'b11101);
            end
            step();
        end
        drive(1, 0, 0, 0);
        chk("same_post_full", dut.r_full, 2'b10);
        chk("same_pulses", {frame_done, rd_done}, 2'b11);
        chk("same_banks", {wr_bank, rd_bank, in_ready, rd_valid}, 4'b0111);
        step();

        // flush at pixel 500, then async reset mid-read
        do_reset();
        for (int t = 0; t < 500; t++) begin
            drive(1, 0, 1, 0);
            step();
        end
        drive(1, 1, 1, 0);
        chk("clr_block", {in_ready, wr_en}, 2'b00);
        step();
        drive(1, 0, 0, 0);
        chk("clr_state", {dut.r_full, wr_row, wr_col, wr_bank, frame_done}, 0);
        step();
        for (int t = 0; t < NPIX; t++) begin
            drive(1, 0, 1, 0);
            step();
        end
        rdc = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 1);
            if (rd_done) rdc++;
            step();
        end
        rst_n = 1'b0;
        drive(1, 0, 1, 1);
        chk("rstmid_no_rd_done", rdc + rd_done, 0);
        chk("rstmid_io", {in_ready, rd_valid, frame_done, rd_done}, 4'b0000);
        chk("rstmid_idx", {dut.r_full, wr_bank, wr_row, wr_col, rd_bank, rd_row_sel},
            {16'd0, one_sel});
        chk("rstmid_cnt", frm_cnt, 0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        chk("rstmid_after", {in_ready, rd_valid}, 2'b10);

        // enable gating mid-frame with overlapped read
        do_reset();
        for (int t = 0; t < NPIX; t++) begin
            drive(1, 0, 1, 0);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 1);
            step();
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 1);
            if (in_ready || rd_valid || wr_en || wr_col != 6'd5 || !wr_bank
                || rd_row_sel != (one_sel << 5) || frame_done || rd_done) bad++;
            step();
        end
        chk("en_freeze", bad, 0);
        drive(1, 0, 1, 1);
        chk("en_resume", {in_ready, wr_en, rd_valid, wr_bank, wr_row, wr_col, rd_bank},
            {4'b1111, 6'd0, 6'd5, 1'b0});
        chk("en_resume_sel", rd_row_sel, one_sel << 5);
        step();
        drive(1, 0, 1, 1);
        chk("en_advance", {wr_col, rd_row_sel}, {6'd6, one_sel << 6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/pingpong_ctrl.md
# pingpong_ctrl

Sequencing controller for the 34×34 ping-pong pixel buffer. It accepts a row-major pixel stream with a valid/ready handshake and produces the write bank, row and column for each accepted pixel. It tracks which of the two banks holds a complete frame and steps a one-hot row select across the full bank for the downstream PE array. Writes into one bank overlap reads from the other. Back-pressure is applied only when both banks are full.

## Interface

- DIM, 34, frame height and width in pixels; legal range 2..64.
- AW, $clog2(DIM) (6 for 34), width of the row and column indices.
- CNT_W, 16, width of the status counters (used only with PPB_STATUS_EN).

- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, all state is frozen, in_ready=0 and rd_valid=0.
- clr  in  1  synchronous flush; takes priority over all other inputs.
- in_valid  in  1  input pixel present.
- in_ready  out  1  controller accepts the pixel this cycle.
- wr_en  out  1  write strobe, equal to in_valid & in_ready.
- wr_bank  out  1  bank being written; 0=A, 1=B.
- wr_row  out  AW  row index of the current write.
- wr_col  out  AW  column index of the current write.
- frame_done  out  1  one-cycle pulse on the cycle after the last pixel of a frame is written.
- rd_valid  out  1  a row of the read bank is available.
- rd_ready  in  1  consumer takes the row this cycle.
- rd_bank  out  1  bank being read; drives the buffer's ioswitch.
- rd_row_sel  out  DIM  one-hot row select for the read bank (data_choose).
- rd_done  out  1  one-cycle pulse on the cycle after the last row of a bank is taken.
- frm_cnt  out  CNT_W  frames written (PPB_STATUS_EN only).
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0 (PPB_STATUS_EN only).

## Operation

- State registers:
  - full[1:0], one flag per bank.
  - wr_bank, wr_row, wr_col.
  - rd_bank, rd_row (binary).
  - frame_done and rd_done registers.
- Reset value of every output:
  - full=2'b00; wr_bank=0, wr_row=0, wr_col=0; rd_bank=0, rd_row=0.
  - in_ready=0 while rst_n=0.
  - wr_en=0, frame_done=0, rd_valid=0, rd_done=0.
  - rd_row_sel = one-hot bit 0.
  - frm_cnt=0, stall_cnt=0.
- Write side:
  - in_ready = en & ~full[wr_bank] & ~clr.
  - On accept: wr_col increments; at DIM-1 it wraps to 0 and wr_row increments.
  - On accepting pixel (DIM-1, DIM-1): full[wr_bank] is set, wr_bank toggles, wr_row and wr_col return to 0, and frame_done pulses.
- Read side:
  - rd_valid = en & full[rd_bank] & ~clr.
  - rd_row_sel = 1 << rd_row.
  - On rd_valid & rd_ready: rd_row increments.
  - On taking row DIM-1: full[rd_bank] is cleared, rd_bank toggles, rd_row returns to 0, and rd_done pulses.
- Bank states, per bank: EMPTY (full=0, not written) → FILLING (wr_bank points to it) → FULL (full=1) → DRAINING (rd_bank points to it and full=1) → EMPTY.
- Simultaneous set and clear always target different banks, so the same-cycle write completion of one bank and read completion of the other are both honoured.
- clr forces all state to its reset values at the next edge. Partially written frames and partially read frames are discarded. No frame_done or rd_done pulse is issued for them.
- Index arithmetic is unsigned AW-bit. Indices never exceed DIM-1.

## Timing

- wr_bank, wr_row and wr_col are registered. They are valid on the cycle in which wr_en=1; the buffer samples them on that edge.
- Frame-complete to read latency: 1 cycle. If the last pixel is accepted at edge n, then full is set at n, rd_valid=1 from cycle n+1 (when that bank is rd_bank), and frame_done=1 during cycle n+1.
- Read throughput: one row per cycle while rd_ready=1. A full bank drains in DIM accepted cycles.
- Bank reuse: after the last row is taken at edge m, in_ready for that bank can rise at cycle m+1.
- en=0 freezes all counters. Pulses already registered still complete their single cycle.
- Reset mid-frame behaves the same as clr.

## Configuration

- PPB_STATUS_EN defined:
  - frm_cnt increments on each frame_done.
  - stall_cnt increments each cycle with in_valid & ~in_ready & en.
  - Both counters saturate at all-ones and are cleared by rst_n and by clr.
- PPB_STATUS_EN undefined: frm_cnt and stall_cnt are tied to 0 and no counter flops are built.

## Test plan

- Stream a single frame (DIM=34, 1156 pixels, in_valid held at 1, rd_ready=0):
  - wr_row/wr_col run (0,0)…(33,33).
  - frame_done pulses once.
  - rd_valid rises 1 cycle after the last accept.
  - wr_bank=1 afterwards.
- Three frames with rd_ready=0:
  - in_ready drops after frame 2.
  - stall_cnt counts the stalled cycles (with PPB_STATUS_EN).
  - After 34 rd_ready cycles, in_ready returns the next cycle.
- Concurrent operation, rd_ready=1, continuous input:
  - The read of bank A finishes while bank B fills.
  - rd_bank alternates 0,1,0…
  - rd_row_sel walks bit 0→33 per bank.
  - No stall occurs.
- Same-cycle completion:
  - Align the last pixel written to B with the last row read from A.
  - Expect full to go from 2'b01 to 2'b10 in one edge, with frame_done and rd_done both pulsing.
- Flush and reset: assert clr at pixel 500, then deassert rst_n mid-read.
  - All indices return to 0 and full=00.
  - No done pulses are issued.
  - frm_cnt=0.
- en gating: drop en for 10 cycles mid-frame.
  - in_ready and rd_valid stay 0.
  - wr_col and rd_row hold.
  - Operation resumes from the same indices.
